// File: rtl/sobel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_pkg : shared types for the Sobel frame sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
package sobel_pkg;

  localparam int unsigned PKG_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } frame_state_t;

  typedef logic [3*PKG_DATA_WIDTH-1:0] pixel_t;

  function automatic int cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_frame_ctrl : feeds image_processor one frame, primes/flushes its
// line buffers and emits exactly WIDTH*HEIGHT results.  Rev 1.0
// ---------------------------------------------------------------------------
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int HEIGHT     = 100,
  parameter int DATA_WIDTH = 8,
  parameter int FILL_LAT   = WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [3*DATA_WIDTH-1:0] s_data,
  output logic                    proc_shift_en,
  output logic [3*DATA_WIDTH-1:0] proc_data_in,
  input  logic [3*DATA_WIDTH-1:0] proc_out_pixel,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [3*DATA_WIDTH-1:0] m_data,
  output logic                    m_last
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = cnt_width(N + FILL_LAT + 1);

  localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
  localparam logic [CW-1:0] FILL_LAT_C = CW'(FILL_LAT);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((FILL_LAT >= 2) ? (FILL_LAT - 2) : 0);
  // With a single-stage pipeline there is nothing to flush.
  localparam frame_state_t  AFTER_RUN  = (FILL_LAT == 1) ? DRAIN : FLUSH;

  frame_state_t  state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CW-1:0] shift_cnt_q, shift_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          pend_q, pend_d;

  logic can_shift, src_ok, shift, in_hs, m_hs;

  always_comb begin
    can_shift = !pend_q || m_ready;
    src_ok    = (state_q == RUN && s_valid) || (state_q == FLUSH);
    shift     = src_ok && can_shift;
    in_hs     = (state_q == RUN) && s_valid && can_shift;
    m_hs      = pend_q && m_ready;

    state_d     = state_q;
    in_cnt_d    = in_hs ? in_cnt_q + 1'b1 : in_cnt_q;
    shift_cnt_d = shift ? shift_cnt_q + 1'b1 : shift_cnt_q;
    out_cnt_d   = m_hs ? out_cnt_q + 1'b1 : out_cnt_q;
    flush_cnt_d = (state_q == FLUSH && shift) ? flush_cnt_q + 1'b1 : flush_cnt_q;

    // A shift past the fill latency loads a fresh result, even while handing one off.
    if (shift && shift_cnt_d >= FILL_LAT_C) begin
      pend_d = 1'b1;
    end else if (m_hs) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
        in_cnt_d    = '0;
        flush_cnt_d = '0;
        shift_cnt_d = '0;
        out_cnt_d   = '0;
        pend_d      = 1'b0;
      end
      RUN: begin
        if (in_hs && in_cnt_q == LAST_IDX) begin
          state_d = AFTER_RUN;
        end
      end
      FLUSH: begin
        if (shift && flush_cnt_q == FLUSH_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_hs && out_cnt_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d     = IDLE;
      in_cnt_d    = '0;
      flush_cnt_d = '0;
      shift_cnt_d = '0;
      out_cnt_d   = '0;
      pend_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      shift_cnt_q <= '0;
      out_cnt_q   <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      out_cnt_q   <= out_cnt_d;
      pend_q      <= pend_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign s_ready       = (state_q == RUN) && can_shift;
  assign proc_shift_en = shift;
  assign proc_data_in  = (state_q == RUN) ? s_data : '0;
  assign m_valid       = pend_q;
  assign m_data        = proc_out_pixel;
  assign m_last        = pend_q && (out_cnt_q == LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sobel_frame_ctrl : directed bench, image_processor replaced by delay lines.
// ---------------------------------------------------------------------------
module tb_sobel_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start6 = 1'b0, start1 = 1'b0, abort = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic [PW-1:0] s_data = '0;

  logic busy6, done6, s_ready6, pse6, mv6, ml6;
  logic [PW-1:0] pdi6, pop6, md6;
  logic busy1, done1, s_ready1, pse1, mv1, ml1;
  logic [PW-1:0] pdi1, pop1, md1;

  logic [6*PW-1:0] sr6;
  logic [PW-1:0]   sr1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8), .FILL_LAT(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .abort(abort), .busy(busy6), .done(done6),
    .s_valid(s_valid), .s_ready(s_ready6), .s_data(s_data),
    .proc_shift_en(pse6), .proc_data_in(pdi6), .proc_out_pixel(pop6),
    .m_valid(mv6), .m_ready(m_ready), .m_data(md6), .m_last(ml6)
  );

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8), .FILL_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .busy(busy1), .done(done1),
    .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .proc_shift_en(pse1), .proc_data_in(pdi1), .proc_out_pixel(pop1),
    .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_last(ml1)
  );

  // Stand-ins for image_processor: depth-6 and depth-1 delay lines.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr6 <= '0;
      sr1 <= '0;
    end else begin
      if (pse6) sr6 <= {sr6[5*PW-1:0], pdi6};
      if (pse1) sr1 <= pdi1;
    end
  end
  assign pop6 = sr6[6*PW-1 -: PW];
  assign pop1 = sr1;

  function automatic logic [PW-1:0] pix(input int k);
    logic [7:0] r, g, b;
    r = 8'(8'h10 + k);
    g = 8'(8'h80 + 2 * k);
    b = 8'(8'hF0 - k);
    return {r, g, b};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input bit use1, input bit stall, input bit gaps,
                           input bit rst_mode, input bit abort_mode);
    int fl = use1 ? 1 : 6;
    int in_idx = 0, out_idx = 0, shifts = 0, cyc = 0, stall_left = 0, last_hs = -10;
    bit first_mv = 0, got_done = 0, stalled_once = 0;
    logic b, d, sr, pe, mv, ml;
    logic [PW-1:0] md;

    @(negedge clk);
    if (use1) start1 = 1'b1; else start6 = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    start6 = 1'b0;
    #1;
    check_eq("busy_after_start", use1 ? busy1 : busy6, 1);

    while (cyc < 300) begin
      s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      s_data  = pix(in_idx);
      m_ready = (stall_left == 0);
      start6  = abort_mode && (in_idx == 3);
      abort   = abort_mode && (shifts == N + 2);

      if (rst_mode && in_idx == 5) begin
        rst = 1'b1;
        #1;
        check_eq("rst_busy", busy6, 0);
        check_eq("rst_done", done6, 0);
        check_eq("rst_s_ready", s_ready6, 0);
        check_eq("rst_shift_en", pse6, 0);
        check_eq("rst_m_valid", mv6, 0);
        check_eq("rst_m_last", ml6, 0);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        return;
      end

      #1;
      if (use1) begin
        b = busy1; d = done1; sr = s_ready1; pe = pse1; mv = mv1; ml = ml1; md = md1;
      end else begin
        b = busy6; d = done6; sr = s_ready6; pe = pse6; mv = mv6; ml = ml6; md = md6;
      end

      if (!first_mv && mv) begin
        first_mv = 1;
        check_eq("first_mv_after_shifts", shifts, fl);
      end
      if (stall_left > 0) begin
        check_eq("stall_m_valid", mv, 1);
        check_eq("stall_shift_en", pe, 0);
        check_eq("stall_s_ready", sr, 0);
        check_eq("stall_m_data", md, pix(out_idx));
        stall_left--;
      end
      if (gaps && b && in_idx < N) begin
        check_eq("gap_shift_only_on_accept", pe, s_valid & sr);
      end

      if (s_valid && sr) in_idx++;
      if (pe) shifts++;
      if (mv && m_ready) begin
        check_eq("m_data", md, pix(out_idx));
        check_eq("m_last", ml, out_idx == N - 1);
        out_idx++;
        last_hs = cyc;
        if (stall && !stalled_once) begin
          stalled_once = 1;
          stall_left = 4;
        end
      end
      if (d) begin
        got_done = 1;
        check_eq("done_timing", cyc, last_hs + 1);
        break;
      end

      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        start6 = 1'b0;
        s_valid = 1'b0;
        #1;
        check_eq("abort_busy", busy6, 0);
        check_eq("abort_m_valid", mv6, 0);
        check_eq("abort_done", done6, 0);
        repeat (3) begin
          @(negedge clk);
          #1;
          check_eq("abort_no_done", done6, 0);
          check_eq("abort_stays_idle", busy6, 0);
        end
        return;
      end

      @(negedge clk);
      cyc++;
    end

    s_valid = 1'b0;
    m_ready = 1'b1;
    check_eq("done_seen", got_done, 1);
    check_eq("out_count", out_idx, N);
    check_eq("shift_count", shifts, N + fl - 1);
    @(negedge clk);
    #1;
    check_eq("idle_after_done", use1 ? busy1 : busy6, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", busy6, 0);
    check_eq("reset_done", done6, 0);
    check_eq("reset_s_ready", s_ready6, 0);
    check_eq("reset_shift_en", pse6, 0);
    check_eq("reset_m_valid", mv6, 0);
    check_eq("reset_m_last", ml6, 0);
    rst = 1'b0;

    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // reset mid-RUN
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // full rate
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);  // output backpressure
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // input gaps
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // abort in FLUSH

    @(negedge clk);
    start6 = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    abort  = 1'b0;
    #1;
    check_eq("start_abort_idle", busy6, 0);

    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // single-stage pipeline

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
